// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit CPU and its program sequencer:
// opcode encodings, sequencer states and error codes.
`timescale 1ns/1ps
package cpu_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_EXEC,
    ST_PAUSED,
    ST_HALTED
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_t;

  // mv, mvi, add and sub are the only opcodes the datapath can execute;
  // they all share a zero top bit.
  function automatic logic is_cpu_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Execution watchdog: counts EXEC cycles since the last issue and flags
// when the count reaches TIMEOUT-1, i.e. during the TIMEOUT-th EXEC cycle.
`timescale 1ns/1ps
module seq_watchdog #(
  parameter int TIMEOUT = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Clear wins over enable; the count parks at the terminal value so it can never wrap back to zero.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TERMINAL)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TERMINAL);

endmodule

// File: rtl/instr_fetch_seq.sv
// Program sequencer in front of the 9-bit CPU: fetches one word per
// instruction from the synchronous instruction RAM, strobes Run, waits for
// Done and advances the PC. Stops on HALT, on LAST_ADDR, or on an error.
`timescale 1ns/1ps
module instr_fetch_seq
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 31,
  parameter int TIMEOUT    = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Pause,
  input  logic [8:0]        DATAOUT,
  input  logic              Done,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [1:0]        Err_code,
  output logic [7:0]        Instr_count
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(LAST_ADDR);

  seq_state_t        state;
  logic [ADDR_W-1:0] pc;
  logic              error_flag;
  err_code_t         err_code;
  logic [7:0]        instr_count;
  logic [2:0]        opcode;
  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired;
  logic              unused_operand_bits;

  // Only the opcode field matters here; register operands belong to the CPU.
  assign opcode              = DATAOUT[8:6];
  assign unused_operand_bits = ^DATAOUT[5:0];

  assign wd_clear  = (state == ST_ISSUE);
  assign wd_enable = (state == ST_EXEC);

  seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Main sequencer: state, PC, completed-instruction count and sticky error.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      pc          <= START_PC;
      error_flag  <= 1'b0;
      err_code    <= ERR_NONE;
      instr_count <= 8'd0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (Start) begin
            pc          <= START_PC;
            error_flag  <= 1'b0;
            err_code    <= ERR_NONE;
            instr_count <= 8'd0;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (is_cpu_op(opcode)) begin
            state <= ST_EXEC;
          end else if (opcode == OP_HALT) begin
            err_code <= ERR_NONE;
            state    <= ST_HALTED;
          end else begin
            error_flag <= 1'b1;
            err_code   <= ERR_ILLEGAL;
            state      <= ST_HALTED;
          end
        end
        ST_EXEC: begin
          if (Done) begin
            instr_count <= instr_count + 8'd1;
            if (pc == LAST_PC) begin
              state <= ST_HALTED;
            end else begin
              pc    <= pc + 1'b1;
              state <= Pause ? ST_PAUSED : ST_FETCH;
            end
          end else if (wd_expired) begin
            error_flag <= 1'b1;
            err_code   <= ERR_TIMEOUT;
            state      <= ST_HALTED;
          end
        end
        ST_PAUSED: begin
          if (!Pause) begin
            state <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ADDRESS     = pc;
  assign Run         = (state == ST_ISSUE) && is_cpu_op(opcode);
  assign Busy        = (state == ST_FETCH) || (state == ST_ISSUE) ||
                       (state == ST_EXEC)  || (state == ST_PAUSED);
  assign Halted      = (state == ST_HALTED);
  assign Error       = error_flag;
  assign Err_code    = err_code;
  assign Instr_count = instr_count;

endmodule
